fifo_ctrl: RTL and testbench
============================

# fifo_ctrl

Pointer and flag controller for the synchronous FIFO. Sits directly upstream of DUAL_PORT_RAM, driving its write port (port 0) and read port (port 1) and returning the RAM's registered read data to the consumer with a valid strobe. Owns occupancy tracking, full/empty and threshold flags, sticky overflow/underflow errors and a synchronous flush.

## Interface
- DATA_WIDTH, 8, payload width; must match the RAM DATA_RAM_WIDTH
- ADDR_WIDTH, 8, RAM address width; DEPTH = 2**ADDR_WIDTH
- AF_TH, DEPTH-4, almost_full asserted when count >= AF_TH
- AE_TH, 4, almost_empty asserted when count <= AE_TH

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset: asynchronous assert, active-low
- clear  in  1  synchronous flush of pointers and occupancy
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write payload
- rd_en  in  1  read request
- rd_data  out  DATA_WIDTH  read payload; valid only while rd_valid=1
- rd_valid  out  1  rd_data holds the entry popped on the previous cycle
- full / empty  out  1 each  occupancy flags
- almost_full / almost_empty  out  1 each  threshold flags
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow / underflow  out  1 each  sticky error flags
- clr_err  in  1  synchronous clear of overflow/underflow
- ram_addr_0  out  ADDR_WIDTH  RAM write address
- ram_ce_0 / ram_wr_0  out  1 each  RAM port-0 enable and write select
- ram_data_0  out  DATA_WIDTH  RAM write data
- ram_addr_1  out  ADDR_WIDTH  RAM read address
- ram_ce_1  out  1  RAM port-1 enable
- ram_wr_1  out  1  RAM port-1 write select; constant 0
- ram_data_1  in  DATA_WIDTH  RAM registered read data

## Operation
- wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide. The MSB is the wrap bit.
- RAM addresses are the low ADDR_WIDTH bits of each pointer.
- count register: count = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1).
- Flags are decoded from registered count only:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - almost_full and almost_empty use AF_TH and AE_TH.
- wr_acc = wr_en & !full & !clear.
- rd_acc = rd_en & !empty & !clear.
- Full and empty are evaluated on the current count. A write when full is rejected even if a read is accepted in the same cycle. A read when empty is rejected even if a write is accepted in the same cycle.
- RAM drive is combinational from the current state and requests:
  - ram_ce_0 = ram_wr_0 = wr_acc
  - ram_addr_0 = wr_ptr low bits; ram_data_0 = wr_data
  - ram_ce_1 = rd_acc; ram_addr_1 = rd_ptr low bits
- On wr_acc, wr_ptr increments by 1. On rd_acc, rd_ptr increments by 1. Both wrap naturally.
- count update: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- rd_valid is rd_acc registered. rd_data = ram_data_1 (pass-through).
- overflow is set by wr_en & full & !clear. underflow is set by rd_en & empty & !clear.
  - Both stay set until clr_err or reset.
  - If set and clr_err occur together, set wins.
- clear sets wr_ptr=rd_ptr=0, count=0 and rd_valid=0 next cycle. It does not touch the error flags or RAM contents.
- Reset values: all pointers 0, count 0, empty=1, almost_empty=1, full=0, almost_full=0 (given AF_TH>0), rd_valid=0, overflow=underflow=0. rd_data reads 0 because the RAM also resets.

## Timing
- Write: data is in the RAM at the edge where wr_acc=1. Flags and count reflect it after that edge.
- Read latency is 1 cycle. With rd_acc in cycle N, rd_valid=1 and rd_data=entry in cycle N+1.
- Back-to-back reads give one entry per cycle at full throughput.
- First-write to read: a write in cycle N makes empty=0 in N+1. A read then accepted in N+1 produces data in N+2.
- Simultaneous write and read at count=DEPTH-1 or 1: both are accepted and count is unchanged. The RAM read/write addresses differ.
- Pointer wrap after DEPTH writes: wr_ptr MSB toggles. With count=DEPTH, full=1, even though the address bits are equal.
- Asynchronous reset mid-transfer: all state clears immediately, and an in-flight rd_valid is dropped.

## Test plan
- **Reset:** assert rst_n=0 mid-stream -> immediately empty=1, count=0, rd_valid=0, flags 0.
- **Fill/drain (ADDR_WIDTH=3, DEPTH 8):** write 0x10..0x17 -> full=1, count=8, almost_full from count 4. Read 8 -> rd_data 0x10..0x17 in order, each one cycle after rd_en, then empty=1.
- **Overflow/underflow:** wr_en at full -> count stays 8, overflow=1, RAM port 0 is not enabled. rd_en at empty -> underflow=1, rd_valid stays 0. Pulse clr_err -> both 0.
- **Simultaneous:** at count=3, wr_en and rd_en together for 10 cycles -> count stays 3, data order is preserved across the pointer wrap.
- **Empty+write+read same cycle:** at count=0, raise wr_en=rd_en=1 -> write accepted, read rejected, count=1, underflow=1.
- **Flush:** at count=5, clear=1 plus wr_en -> next cycle count=0, empty=1, write not stored. The next write/read returns the new value.

Source files
------------

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and flag controller driving a dual-port RAM with registered read data.
module fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int AF_TH      = (1 << ADDR_WIDTH) - 4,
    parameter int AE_TH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err,
    output logic [ADDR_WIDTH-1:0] ram_addr_0,
    output logic                  ram_ce_0,
    output logic                  ram_wr_0,
    output logic [DATA_WIDTH-1:0] ram_data_0,
    output logic [ADDR_WIDTH-1:0] ram_addr_1,
    output logic                  ram_ce_1,
    output logic                  ram_wr_1,
    input  logic [DATA_WIDTH-1:0] ram_data_1
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_V = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_V    = AF_TH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_V    = AE_TH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic                rd_valid_q, rd_valid_d, overflow_q, overflow_d, underflow_q, underflow_d;
    logic                wr_acc, rd_acc;

    assign full         = count_q == DEPTH_V;
    assign empty        = count_q == '0;
    assign almost_full  = count_q >= AF_V;
    assign almost_empty = count_q <= AE_V;
    assign count        = count_q;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = ram_data_1;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign ram_ce_0     = wr_acc;
    assign ram_wr_0     = wr_acc;
    assign ram_addr_0   = wr_ptr_q[ADDR_WIDTH-1:0];
    assign ram_data_0   = wr_data;
    assign ram_ce_1     = rd_acc;
    assign ram_addr_1   = rd_ptr_q[ADDR_WIDTH-1:0];
    assign ram_wr_1     = 1'b0;

    always_comb begin
        wr_acc      = wr_en & ~full & ~clear;
        rd_acc      = rd_en & ~empty & ~clear;
        wr_ptr_d    = clear ? '0 : wr_ptr_q + (wr_acc ? ONE : '0);
        rd_ptr_d    = clear ? '0 : rd_ptr_q + (rd_acc ? ONE : '0);
        count_d     = clear                ? '0 :
                      (wr_acc & ~rd_acc)   ? count_q + ONE :
                      (rd_acc & ~wr_acc)   ? count_q - ONE : count_q;
        rd_valid_d  = rd_acc;
        // a new error event outranks a simultaneous clr_err
        overflow_d  = (wr_en & full & ~clear) | (overflow_q & ~clr_err);
        underflow_d = (rd_en & empty & ~clear) | (underflow_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: scoreboard bench for fifo_ctrl (DEPTH 8) with a behavioural registered-read RAM.
module tb_fifo_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       clear = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
    logic [7:0] wr_data = '0, rd_data, ram_data_0, ram_data_1;
    logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;
    logic [2:0] ram_addr_0, ram_addr_1;
    logic       ram_ce_0, ram_wr_0, ram_ce_1, ram_wr_1;
    logic [7:0] mem [8];
    logic [7:0] exp_q [$];
    int         n_chk = 0, n_err = 0, mcnt = 0;

    fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_TH(4), .AE_TH(2)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err),
        .ram_addr_0(ram_addr_0), .ram_ce_0(ram_ce_0), .ram_wr_0(ram_wr_0), .ram_data_0(ram_data_0),
        .ram_addr_1(ram_addr_1), .ram_ce_1(ram_ce_1), .ram_wr_1(ram_wr_1), .ram_data_1(ram_data_1)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ram_data_1 <= '0;
        else begin
            if (ram_ce_1 && !ram_wr_1) ram_data_1 <= mem[ram_addr_1];
            if (ram_ce_0 && ram_wr_0) mem[ram_addr_0] <= ram_data_0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (exp_q.size() == 0) chk("unexpected_rd_valid", 32'(rd_data), 32'hdead);
            else chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic [7:0] e, input logic c);
        logic wa, ra;
        wr_en = w; wr_data = d; rd_en = r; clear = c;
        wa = w && mcnt < 8 && !c;
        ra = r && mcnt > 0 && !c;
        if (ra) exp_q.push_back(e);
        mcnt = c ? 0 : mcnt + int'(wa) - int'(ra);
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
    endtask

    task automatic pulse_clr_err();
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_count", 32'(count), 0);
        chk("rst_flags", {28'd0, full, almost_full, almost_empty, rd_valid}, 32'b0010);
        chk("rst_err", {30'd0, overflow, underflow}, 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'h10 + 8'(i), 1'b0, 8'h00, 1'b0);
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_af", 32'(almost_full), 32'(i + 1 >= 4));
        end
        chk("full", 32'(full), 1);
        chk("full_not_empty", 32'(empty), 0);
        wr_en = 1'b1; wr_data = 8'hAA;
        #1;
        chk("ovf_ram_ce_0", {30'd0, ram_ce_0, ram_wr_0}, 0);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        chk("ovf_count", 32'(count), 8);
        chk("overflow", 32'(overflow), 1);
        chk("no_underflow", 32'(underflow), 0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, 1'b1, 8'h10 + 8'(i), 1'b0);
            chk("drain_count", 32'(count), 32'(7 - i));
            chk("drain_ae", 32'(almost_empty), 32'(7 - i <= 2));
        end
        chk("drained_empty", 32'(empty), 1);
        step(1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
        chk("underflow", 32'(underflow), 1);
        chk("udf_no_valid", 32'(rd_valid), 0);
        pulse_clr_err();
        chk("clr_err", {30'd0, overflow, underflow}, 0);
        rd_en = 1'b1; clr_err = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0; clr_err = 1'b0;
        chk("set_wins", 32'(underflow), 1);
        pulse_clr_err();
        for (int i = 0; i < 3; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'h23 + 8'(i), 1'b1, 8'h20 + 8'(i), 1'b0);
            chk("simul_count", 32'(count), 3);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 8'h2A + 8'(i), 1'b0);
        step(1'b1, 8'h30, 1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h31, 1'b1, 8'h30, 1'b0);
        chk("simul1_count", 32'(count), 1);
        step(1'b0, 8'h00, 1'b1, 8'h31, 1'b0);
        step(1'b1, 8'h40, 1'b1, 8'h00, 1'b0);
        chk("ew_count", 32'(count), 1);
        chk("ew_underflow", 32'(underflow), 1);
        chk("ew_no_valid", 32'(rd_valid), 0);
        step(1'b0, 8'h00, 1'b1, 8'h40, 1'b0);
        pulse_clr_err();
        for (int i = 0; i < 5; i++) step(1'b1, 8'h50 + 8'(i), 1'b0, 8'h00, 1'b0);
        chk("pre_flush_count", 32'(count), 5);
        step(1'b1, 8'h55, 1'b0, 8'h00, 1'b1);
        chk("flush_count", 32'(count), 0);
        chk("flush_empty", 32'(empty), 1);
        step(1'b1, 8'h60, 1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1, 8'h60, 1'b0);
        chk("post_flush_empty", 32'(empty), 1);
        step(1'b1, 8'h70, 1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h71, 1'b0, 8'h00, 1'b0);
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        chk("inflight_valid", 32'(rd_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_flags", {28'd0, full, almost_full, almost_empty, rd_valid}, 32'b0010);
        mcnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1, 8'h77, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
